// File: rtl/phv_deparser_pkg.sv
// rtl/phv_deparser_pkg.sv - shared widths, tag bit positions, packet markers and FSM state type
package phv_deparser_pkg;

   localparam int HEAD_WIDTH    = 1024;
   localparam int TAG_WIDTH     = 16;
   localparam int TAG_START_BIT = 0;
   localparam int TAG_TAIL_BIT  = 1;
   localparam int TAG_VALID_BIT = 2;
   localparam int PKT_WIDTH     = 134;
   localparam int PKT_FIFO_AW   = 9;
   localparam int PHV_FIFO_AW   = 3;

   localparam logic [1:0] PKT_HEAD = 2'b01;
   localparam logic [1:0] PKT_TAIL = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT_PHV,
      ST_SUBST,
      ST_PASS,
      ST_FLUSH,
      ST_DROP
   } state_t;

endpackage

// File: rtl/deparser_sync_fifo.sv
// rtl/deparser_sync_fifo.sv - show-ahead synchronous FIFO; a pop in the same cycle frees room for a write when full
module deparser_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int AW    = 3
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_wr_en,
   input  logic [WIDTH-1:0] i_din,
   input  logic             i_rd_en,
   output logic [WIDTH-1:0] o_dout,
   output logic             o_empty,
   output logic             o_full
);

   localparam int DEPTH = 1 << AW;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wptr;
   logic [AW-1:0]    r_rptr;
   logic [AW:0]      r_cnt;
   logic             w_wr;
   logic             w_rd;

   assign o_empty = (r_cnt == '0);
   assign o_full  = (r_cnt == (AW+1)'(DEPTH));
   assign w_rd    = i_rd_en && !o_empty;
   assign w_wr    = i_wr_en && (!o_full || w_rd);
   assign o_dout  = r_mem[r_rptr];

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wptr <= '0;
         r_rptr <= '0;
         r_cnt  <= '0;
      end else begin
         if (w_wr) r_wptr <= r_wptr + AW'(1);
         if (w_rd) r_rptr <= r_rptr + AW'(1);
         case ({w_wr, w_rd})
            2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
            2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   // Storage is not reset; validity is tracked entirely by the pointers.
   always_ff @(posedge i_clk) begin
      if (w_wr) r_mem[r_wptr] <= i_din;
   end

endmodule

// File: rtl/phv_deparser.sv
// rtl/phv_deparser.sv - rebuilds packets by overwriting leading words with PHV lanes; PHV_DROP_EN drops packets whose START slice has VALID=0
module phv_deparser
   import phv_deparser_pkg::*;
#(
   parameter int HEAD_W = HEAD_WIDTH,
   parameter int TAG_W  = TAG_WIDTH,
   parameter int PKT_AW = PKT_FIFO_AW,
   parameter int PHV_AW = PHV_FIFO_AW
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_pkt_valid,
   input  logic [133:0]          i_pkt,
   input  logic                  i_phv_valid,
   input  logic [HEAD_W+TAG_W-1:0] i_phv,
   input  logic                  i_ready,
   output logic                  o_pkt_valid,
   output logic [133:0]          o_pkt,
   output logic                  o_err_ovf,
   output logic [15:0]           o_err_mismatch
);

   localparam int PW  = HEAD_W + TAG_W;
   localparam int WPS = HEAD_W / 128;
   localparam int LW  = (WPS > 1) ? $clog2(WPS) : 1;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [LW-1:0]   r_lane;
   logic [LW-1:0]   w_lane_nxt;
   logic            r_out_valid;
   logic [133:0]    r_out_pkt;
   logic            r_ovf;
   logic [15:0]     r_mis;

   logic [133:0]    w_pkt_dout;
   logic            w_pkt_empty;
   logic            w_pkt_full;
   logic            w_pkt_pop;
   logic [PW-1:0]   w_phv_dout;
   logic            w_phv_empty;
   logic            w_phv_full;
   logic            w_phv_pop;

   logic            w_can_out;
   logic            w_load;
   logic [133:0]    w_load_data;
   logic            w_mis_inc;
   logic            w_start;
   logic            w_subst;
   logic            w_pkt_head;
   logic            w_pkt_tail;
   logic            w_phv_start;
   logic            w_phv_tail;
   logic            w_last_lane;
   logic [127:0]    w_lane_data;
   logic            w_unused_tags;
`ifdef PHV_DROP_EN
   logic            r_drop_more;
   logic            w_drop_more_nxt;
   logic            w_phv_valid;
   assign w_phv_valid = w_phv_dout[HEAD_W+TAG_VALID_BIT];
`endif

   deparser_sync_fifo #(.WIDTH(134), .AW(PKT_AW)) u_pkt_fifo (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_wr_en (i_pkt_valid),
      .i_din   (i_pkt),
      .i_rd_en (w_pkt_pop),
      .o_dout  (w_pkt_dout),
      .o_empty (w_pkt_empty),
      .o_full  (w_pkt_full)
   );

   deparser_sync_fifo #(.WIDTH(PW), .AW(PHV_AW)) u_phv_fifo (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_wr_en (i_phv_valid),
      .i_din   (i_phv),
      .i_rd_en (w_phv_pop),
      .o_dout  (w_phv_dout),
      .o_empty (w_phv_empty),
      .o_full  (w_phv_full)
   );

   assign w_can_out     = !r_out_valid || i_ready;
   assign w_pkt_head    = (w_pkt_dout[133:132] == PKT_HEAD);
   assign w_pkt_tail    = (w_pkt_dout[133:132] == PKT_TAIL);
   assign w_phv_start   = w_phv_dout[HEAD_W+TAG_START_BIT];
   assign w_phv_tail    = w_phv_dout[HEAD_W+TAG_TAIL_BIT];
   assign w_last_lane   = (r_lane == LW'(WPS-1));
   assign w_lane_data   = w_phv_dout[HEAD_W-1-128*int'(r_lane) -: 128];
   assign w_unused_tags = ^w_phv_dout[PW-1:HEAD_W];

   // IDLE/WAIT_PHV fall straight into the substitution action so a head word and
   // its START slice produce output on the very next cycle.
   always_comb begin
      w_state_nxt = r_state;
      w_lane_nxt  = r_lane;
      w_pkt_pop   = 1'b0;
      w_phv_pop   = 1'b0;
      w_load      = 1'b0;
      w_load_data = w_pkt_dout;
      w_mis_inc   = 1'b0;
      w_start     = 1'b0;
      w_subst     = 1'b0;
`ifdef PHV_DROP_EN
      w_drop_more_nxt = r_drop_more;
`endif
      case (r_state)
         ST_IDLE: begin
            if (!w_pkt_empty) begin
               if (w_pkt_head) begin
                  if (!w_phv_empty && w_phv_start) begin
                     w_start = 1'b1;
                  end else begin
                     w_state_nxt = ST_WAIT_PHV;
                     w_phv_pop   = !w_phv_empty;
                  end
               end else begin
                  w_pkt_pop = 1'b1;
               end
            end
         end
         ST_WAIT_PHV: begin
            if (!w_phv_empty) begin
               if (w_phv_start) w_start   = 1'b1;
               else             w_phv_pop = 1'b1;
            end
         end
         ST_SUBST: w_subst = 1'b1;
         ST_PASS: begin
            if (!w_pkt_empty && w_can_out) begin
               w_load    = 1'b1;
               w_pkt_pop = 1'b1;
               if (w_pkt_tail) w_state_nxt = ST_IDLE;
            end
         end
         ST_FLUSH: begin
            if (!w_phv_empty) begin
               w_phv_pop = 1'b1;
               if (w_phv_tail) w_state_nxt = ST_IDLE;
            end
         end
`ifdef PHV_DROP_EN
         ST_DROP: begin
            if (!w_pkt_empty) begin
               w_pkt_pop = 1'b1;
               if (w_pkt_tail) w_state_nxt = r_drop_more ? ST_FLUSH : ST_IDLE;
            end
         end
`endif
         default: w_state_nxt = ST_IDLE;
      endcase

      if (w_start) begin
`ifdef PHV_DROP_EN
         if (!w_phv_valid) begin
            w_pkt_pop       = 1'b1;
            w_phv_pop       = 1'b1;
            w_drop_more_nxt = !w_phv_tail;
            w_state_nxt     = ST_DROP;
         end else begin
            w_subst = 1'b1;
         end
`else
         w_subst = 1'b1;
`endif
      end

      if (w_subst && !w_pkt_empty && !w_phv_empty && w_can_out) begin
         w_load      = 1'b1;
         w_load_data = {w_pkt_dout[133:128], w_lane_data};
         w_pkt_pop   = 1'b1;
         w_lane_nxt  = (w_pkt_tail || w_last_lane) ? '0 : r_lane + LW'(1);
         if (w_pkt_tail) begin
            w_phv_pop = 1'b1;
            if (w_phv_tail) begin
               w_state_nxt = ST_IDLE;
            end else begin
               w_state_nxt = ST_FLUSH;
               w_mis_inc   = 1'b1;
            end
         end else if (w_last_lane) begin
            w_phv_pop   = 1'b1;
            w_state_nxt = w_phv_tail ? ST_PASS : ST_SUBST;
         end else begin
            w_state_nxt = ST_SUBST;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= ST_IDLE;
         r_lane      <= '0;
         r_out_valid <= 1'b0;
         r_out_pkt   <= '0;
         r_ovf       <= 1'b0;
         r_mis       <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_lane  <= w_lane_nxt;
         if (w_can_out) begin
            r_out_valid <= w_load;
            if (w_load) r_out_pkt <= w_load_data;
         end
         if ((i_pkt_valid && w_pkt_full && !w_pkt_pop) ||
             (i_phv_valid && w_phv_full && !w_phv_pop))
            r_ovf <= 1'b1;
         if (w_mis_inc && (r_mis != 16'hFFFF)) r_mis <= r_mis + 16'd1;
      end
   end

`ifdef PHV_DROP_EN
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_drop_more <= 1'b0;
      else          r_drop_more <= w_drop_more_nxt;
   end
`endif

   assign o_pkt_valid    = r_out_valid;
   assign o_pkt          = r_out_pkt;
   assign o_err_ovf      = r_ovf;
   assign o_err_mismatch = r_mis;

endmodule
